// File: rtl/soc_top.sv
// Board-level GPIO SoC: three 8-bit tristate ports steered from switches,
// with synchronized pad/irq inputs, sticky pending flags and an LED status view.

module gpio_port (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_dir,
    input  logic       wr_out,
    input  logic [7:0] wdata,
    input  logic       clr,
    input  logic [7:0] pad_in,
    output logic [7:0] pad_oe,
    output logic [7:0] pad_out,
    output logic [7:0] in_sync,
    output logic       chg_pend
);
    logic [7:0] reg_dir_ff;
    logic [7:0] reg_out_ff;
    logic [7:0] in_meta;
    logic [7:0] in_prev;
    logic       chg_evt;

    // Only pins configured as inputs may raise a change event
    assign chg_evt = |((in_sync ^ in_prev) & ~reg_dir_ff);
    assign pad_oe  = reg_dir_ff;
    assign pad_out = reg_out_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_dir_ff <= 8'h00;
            reg_out_ff <= 8'h00;
            in_meta    <= 8'h00;
            in_sync    <= 8'h00;
            in_prev    <= 8'h00;
            chg_pend   <= 1'b0;
        end else begin
            if (wr_dir) reg_dir_ff <= wdata;
            if (wr_out) reg_out_ff <= wdata;
            in_meta <= pad_in;
            in_sync <= in_meta;
            in_prev <= in_sync;
            if (chg_evt)  chg_pend <= 1'b1;
            else if (clr) chg_pend <= 1'b0;
        end
    end
endmodule

module gpio_top (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sel,
    input  logic        we,
    input  logic        tgt,
    input  logic [7:0]  wdata,
    input  logic        clr,
    input  logic [23:0] pad_in,
    output logic [23:0] pad_oe,
    output logic [23:0] pad_out,
    output logic [23:0] in_sync,
    output logic [2:0]  chg_pend
);
    logic [2:0] hit;

    assign hit[0] = we && (sel == 2'b01);
    assign hit[1] = we && (sel == 2'b10);
    assign hit[2] = we && (sel == 2'b11);

    gpio_port gpio_A (
        .clk(clk), .rst(rst),
        .wr_dir(hit[0] && !tgt), .wr_out(hit[0] && tgt),
        .wdata(wdata), .clr(clr),
        .pad_in(pad_in[7:0]), .pad_oe(pad_oe[7:0]),
        .pad_out(pad_out[7:0]), .in_sync(in_sync[7:0]),
        .chg_pend(chg_pend[0])
    );

    gpio_port gpio_B (
        .clk(clk), .rst(rst),
        .wr_dir(hit[1] && !tgt), .wr_out(hit[1] && tgt),
        .wdata(wdata), .clr(clr),
        .pad_in(pad_in[15:8]), .pad_oe(pad_oe[15:8]),
        .pad_out(pad_out[15:8]), .in_sync(in_sync[15:8]),
        .chg_pend(chg_pend[1])
    );

    gpio_port gpio_C (
        .clk(clk), .rst(rst),
        .wr_dir(hit[2] && !tgt), .wr_out(hit[2] && tgt),
        .wdata(wdata), .clr(clr),
        .pad_in(pad_in[23:16]), .pad_oe(pad_oe[23:16]),
        .pad_out(pad_out[23:16]), .in_sync(in_sync[23:16]),
        .chg_pend(chg_pend[2])
    );
endmodule

module soc_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_ext_i,
    input  logic        irq_soft_i,
    inout  wire  [23:0] gpio_io,
    input  logic [15:0] gp_switch_i,
    output logic [15:0] gp_led_o
);
    logic [15:0] sw_meta;
    logic [15:0] sw_s;
    logic        ext_meta, ext_s, ext_d, ext_pend;
    logic        soft_meta, soft_s, soft_d, soft_pend;
    logic [23:0] pad_oe;
    logic [23:0] pad_out;
    logic [23:0] in_sync;
    logic [2:0]  chg_pend;
    logic [7:0]  led_data;
    logic        unused_sw8;

    assign unused_sw8 = sw_s[8];

    for (genvar i = 0; i < 24; i++) begin : g_pad
        assign gpio_io[i] = pad_oe[i] ? pad_out[i] : 1'bz;
    end

    gpio_top gpio_top_module (
        .clk(clk), .rst(rst),
        .sel(sw_s[15:14]), .we(sw_s[13]), .tgt(sw_s[12]),
        .wdata(sw_s[7:0]), .clr(sw_s[9]),
        .pad_in(gpio_io), .pad_oe(pad_oe), .pad_out(pad_out),
        .in_sync(in_sync), .chg_pend(chg_pend)
    );

    always_comb begin
        led_data = 8'h00;
        case (sw_s[11:10])
            2'b00:   led_data = in_sync[7:0];
            2'b01:   led_data = in_sync[15:8];
            2'b10:   led_data = in_sync[23:16];
            default: led_data = {5'b0, chg_pend};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta   <= 16'h0000;
            sw_s      <= 16'h0000;
            ext_meta  <= 1'b0;
            ext_s     <= 1'b0;
            ext_d     <= 1'b0;
            ext_pend  <= 1'b0;
            soft_meta <= 1'b0;
            soft_s    <= 1'b0;
            soft_d    <= 1'b0;
            soft_pend <= 1'b0;
            gp_led_o  <= 16'h0000;
        end else begin
            sw_meta   <= gp_switch_i;
            sw_s      <= sw_meta;
            ext_meta  <= irq_ext_i;
            ext_s     <= ext_meta;
            ext_d     <= ext_s;
            soft_meta <= irq_soft_i;
            soft_s    <= soft_meta;
            soft_d    <= soft_s;
            // A new edge beats a clear arriving in the same cycle
            if (ext_s && !ext_d) ext_pend <= 1'b1;
            else if (sw_s[9])    ext_pend <= 1'b0;
            if (soft_s && !soft_d) soft_pend <= 1'b1;
            else if (sw_s[9])      soft_pend <= 1'b0;
            gp_led_o <= {5'b0, |chg_pend, soft_pend, ext_pend, led_data};
        end
    end
endmodule

// File: tb/tb_soc_top.sv
// Self-checking bench for soc_top: directed latency/irq/reset scenarios
// followed by randomized port configuration against a pad-level model.

module tb_soc_top;
    logic        clk = 1'b0;
    logic        rst;
    logic        irq_ext_i;
    logic        irq_soft_i;
    logic [15:0] gp_switch_i;
    logic [15:0] gp_led_o;
    wire  [23:0] gpio_io;
    logic [23:0] ext_en;
    logic [23:0] ext_drv;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdir [3];
    logic [7:0] mout [3];
    logic [7:0] mext [3];

    for (genvar i = 0; i < 24; i++) begin : g_ext
        assign gpio_io[i] = ext_en[i] ? ext_drv[i] : 1'bz;
    end

    soc_top dut (
        .clk(clk),
        .rst(rst),
        .irq_ext_i(irq_ext_i),
        .irq_soft_i(irq_soft_i),
        .gpio_io(gpio_io),
        .gp_switch_i(gp_switch_i),
        .gp_led_o(gp_led_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] got,
                       input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        irq_ext_i   = 1'b0;
        irq_soft_i  = 1'b0;
        gp_switch_i = 16'h0000;
        ext_en      = 24'hFFFFFF;
        ext_drv     = 24'h000000;
        #10;
        chk("rst_led", 24'(gp_led_o), 24'h0);
        chk("rst_pads", gpio_io, 24'h0);
        tick(1);
        rst = 1'b0;
        tick(6);
        chk("idle_led", 24'(gp_led_o), 24'h0);

        // Port B input read and change flag
        ext_drv[15:8] = 8'hFF;
        gp_switch_i   = 16'h0400;
        tick(3);
        chk("b_ff", 24'(gp_led_o[7:0]), 24'hFF);
        tick(1);
        chk("b_chg", 24'(gp_led_o[10]), 24'h1);
        gp_switch_i = 16'h0600;
        tick(4);
        gp_switch_i = 16'h0400;
        tick(3);
        chk("b_clr", 24'(gp_led_o[10]), 24'h0);
        ext_drv[15:8] = 8'hAA;
        tick(2);
        chk("b_lat2", 24'(gp_led_o[7:0]), 24'hFF);
        tick(1);
        chk("b_aa", 24'(gp_led_o[7:0]), 24'hAA);
        tick(1);
        chk("b_chg2", 24'(gp_led_o[10]), 24'h1);

        // Port A as output
        ext_en[7:0] = 8'h00;
        gp_switch_i = 16'h60FF;
        tick(4);
        gp_switch_i = 16'h70CC;
        tick(2);
        chk("a_lat2", 24'(gpio_io[7:0]), 24'h00);
        tick(1);
        chk("a_cc", 24'(gpio_io[7:0]), 24'hCC);
        gp_switch_i = 16'h0200;
        tick(4);
        gp_switch_i = 16'h0000;
        tick(4);
        chk("a_view", 24'(gp_led_o[7:0]), 24'hCC);
        gp_switch_i = 16'h0C00;
        tick(4);
        chk("a_nochg", 24'(gp_led_o[7:0]), 24'h00);

        // Interrupt edges, clear, and level hold
        gp_switch_i = 16'h0000;
        irq_ext_i   = 1'b1;
        tick(3);
        chk("ext_lat3", 24'(gp_led_o[8]), 24'h0);
        tick(1);
        chk("ext_set", 24'(gp_led_o[8]), 24'h1);
        irq_soft_i = 1'b1;
        tick(3);
        chk("soft_lat3", 24'(gp_led_o[9]), 24'h0);
        tick(1);
        chk("soft_set", 24'(gp_led_o[9:8]), 24'h3);
        gp_switch_i = 16'h0200;
        tick(4);
        chk("irq_clr", 24'(gp_led_o[9:8]), 24'h0);
        gp_switch_i = 16'h0000;
        tick(6);
        chk("irq_hold", 24'(gp_led_o[9:8]), 24'h0);

        // Change event coinciding with a one-cycle clear
        gp_switch_i = 16'h0C00;
        tick(4);
        chk("v11_pre", 24'(gp_led_o), 24'h0);
        ext_drv[23:16] = 8'hBB;
        gp_switch_i    = 16'h0E00;
        tick(1);
        gp_switch_i = 16'h0C00;
        tick(6);
        chk("simul", 24'(gp_led_o), 24'h0404);

        // Reset while A drives 8'hCC
        gp_switch_i = 16'h0000;
        tick(4);
        chk("pre_rst_a", 24'(gp_led_o[7:0]), 24'hCC);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_led", 24'(gp_led_o), 24'h0);
        ext_en[7:0]  = 8'hFF;
        ext_drv[7:0] = 8'h33;
        #1;
        chk("mid_rst_pad", 24'(gpio_io[7:0]), 24'h33);
        irq_ext_i  = 1'b0;
        irq_soft_i = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(6);
        chk("post_rst_a", 24'(gp_led_o[7:0]), 24'h33);

        // Randomized port configuration
        for (int k = 0; k < 3; k++) begin
            mdir[k] = 8'h00;
            mout[k] = 8'h00;
        end
        mext[0] = 8'h33;
        mext[1] = 8'hAA;
        mext[2] = 8'hBB;
        for (int it = 0; it < 24; it++) begin
            int         p;
            logic       t;
            logic [7:0] d;
            logic [7:0] nv;
            logic [7:0] exp;
            p  = int'($urandom_range(0, 2));
            t  = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            nv = 8'($urandom);
            // Keep the external driver only on pins that stay inputs
            if (!t) ext_en[p*8 +: 8] = ext_en[p*8 +: 8] & ~d;
            gp_switch_i = {2'(p + 1), 1'b1, t, 2'(p), 2'b00, d};
            tick(4);
            if (t) mout[p] = d;
            else   mdir[p] = d;
            gp_switch_i = {2'(p + 1), 1'b0, t, 2'(p), 2'b00, d};
            ext_en[p*8 +: 8]  = ~mdir[p];
            ext_drv[p*8 +: 8] = nv;
            mext[p]           = nv;
            tick(5);
            exp = (mdir[p] & mout[p]) | (~mdir[p] & mext[p]);
            chk("rnd_pad", 24'(gpio_io[p*8 +: 8]), 24'(exp));
            chk("rnd_led", 24'(gp_led_o[7:0]), 24'(exp));
            chk("rnd_hi", 24'(gp_led_o[15:11]), 24'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
